// File: rtl/radix4_div_pkg.sv
// radix4_div_pkg: shared state encoding and default sizing for the radix-4 sequential divider
package radix4_div_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ITER, DONE, DONE_ZERO} state_t;
  localparam int N_DEF = 32;
  localparam int M_DEF = 16;
  localparam int ITERS = N_DEF / 2;
  localparam int CNT_W = $clog2(ITERS);
endpackage

// File: rtl/radix4_digit_sel.sv
// radix4_digit_sel: picks the radix-4 quotient digit for trial remainder t and returns t - q*D
//   t, d1, d2, d3 : N+2-bit trial remainder and divisor multiples D, 2D, 3D
//   q             : selected digit 0..3
//   r             : new partial remainder (always < D, so N bits suffice)
module radix4_digit_sel import radix4_div_pkg::*; #(
  parameter int N = N_DEF
) (
  input  logic [N+1:0] t,
  input  logic [N+1:0] d1,
  input  logic [N+1:0] d2,
  input  logic [N+1:0] d3,
  output logic [1:0]   q,
  output logic [N-1:0] r
);
  logic [N+1:0] m;
  assign q = t >= d3 ? 2'd3 : t >= d2 ? 2'd2 : t >= d1 ? 2'd1 : 2'd0;
  assign m = q == 2'd3 ? d3 : q == 2'd2 ? d2 : q == 2'd1 ? d1 : '0;
  assign r = N'(t - m);
endmodule

// File: rtl/radix4_seq_divider.sv
// radix4_seq_divider: unsigned radix-4 restoring divider, 2 quotient bits per clock
//   clk, rst (async, active-high)
//   start, dividend, divisor : request, operands captured when accepted in IDLE
//   busy                     : high in LOAD and ITER
//   done                     : one-cycle pulse when quotient/remainder/div_by_zero update
//   quotient, remainder      : registered results, held until the next completion
//   div_by_zero              : set with done when the divisor was 0
// Build option: APPROX_DIVISOR_EN rounds the low M divisor bits to a single bit before dividing.
module radix4_seq_divider import radix4_div_pkg::*; #(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int IT = N / 2;
  localparam int CW = $clog2(IT);
  if (N < 4 || N % 2 != 0 || M < 2 || M >= N) begin : g_bad_cfg
    $error("radix4_seq_divider: N must be even and >= 4, and 1 < M < N");
  end
  state_t         state;
  logic [N-1:0]   a, b, dv, r, rn;
  logic [N+1:0]   d1, d2, d3;
  logic [N-3:0]   qr;
  logic [CW-1:0]  cnt;
  logic [1:0]     q;
`ifdef APPROX_DIVISOR_EN
  logic [N-1:0] ap;
  // Keep the upper bits, collapse the low M bits to whichever of 0 / 2^(M-1) the bit density favours.
  assign ap = {b[N-1:M], $countones(b[M-1:0]) > M / 2, {(M-1){1'b0}}};
  assign dv = ap == '0 ? b : ap;
`else
  assign dv = b;
`endif
  radix4_digit_sel #(.N(N)) u_sel (
    .t  ({r, a[N-1:N-2]}),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .q  (q),
    .r  (rn)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      a           <= '0;
      b           <= '0;
      d1          <= '0;
      d2          <= '0;
      d3          <= '0;
      r           <= '0;
      qr          <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a     <= dividend;
          b     <= divisor;
          busy  <= divisor != '0;
          state <= divisor == '0 ? DONE_ZERO : LOAD;
        end
        LOAD: begin
          d1    <= {2'b00, dv};
          d2    <= {1'b0, dv, 1'b0};
          d3    <= {2'b00, dv} + {1'b0, dv, 1'b0};
          r     <= '0;
          qr    <= '0;
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          a   <= a << 2;
          r   <= rn;
          qr  <= (N-2)'({qr, q});
          cnt <= cnt + 1'b1;
          // Results are written on the edge that enters DONE so done and data appear together.
          if (cnt == CW'(IT - 1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= {qr, q};
            remainder   <= rn;
            div_by_zero <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        DONE_ZERO: begin
          state       <= IDLE;
          done        <= 1'b1;
          quotient    <= '1;
          remainder   <= a;
          div_by_zero <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
